// File: rtl/exposure_sequencer.sv
// Frame controller for the pixel array: erase while idle, expose for a clamped
// latched time, then two row-readout phases with centred ADC strobes.
module exposure_sequencer #(
  parameter int EXP_W    = 5,
  parameter int EXP_MIN  = 2,
  parameter int EXP_MAX  = 30,
  parameter int RD_PHASE = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [EXP_W-1:0] ex_time,
  output logic             erase,
  output logic             expose,
  output logic             nre_1,
  output logic             nre_2,
  output logic             adc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, EXPOSE, READ1, READ2} state_t;

  localparam logic [EXP_W-1:0] MIN_L   = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] MAX_L   = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] PH_LAST = EXP_W'(RD_PHASE - 1);
  localparam logic [EXP_W-1:0] ADC_HI  = EXP_W'(RD_PHASE - 2);

  state_t           state_reg, state_next;
  logic [EXP_W-1:0] cnt_reg, cnt_next;
  logic [EXP_W-1:0] ex_clamped;
  logic             done_next;
  logic             adc_next;

  always_comb begin
    ex_clamped = ex_time;
    if (ex_time < MIN_L)
      ex_clamped = MIN_L;
    else if (ex_time > MAX_L)
      ex_clamped = MAX_L;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (init) begin
          cnt_next   = ex_clamped;
          state_next = EXPOSE;
        end
      end
      EXPOSE: begin
        if (cnt_reg == EXP_W'(1)) begin
          cnt_next   = PH_LAST;
          state_next = READ1;
        end else begin
          cnt_next = cnt_reg - EXP_W'(1);
        end
      end
      READ1: begin
        if (cnt_reg == '0) begin
          cnt_next   = PH_LAST;
          state_next = READ2;
        end else begin
          cnt_next = cnt_reg - EXP_W'(1);
        end
      end
      READ2: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - EXP_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The phase index counts up while cnt counts down; the strobe window is
  // symmetric, so it maps directly onto cnt in 1..RD_PHASE-2.
  assign adc_next = ((state_next == READ1) || (state_next == READ2)) &&
                    (cnt_next != '0) && (cnt_next <= ADC_HI);

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      erase     <= 1'b1;
      expose    <= 1'b0;
      nre_1     <= 1'b1;
      nre_2     <= 1'b1;
      adc       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      erase     <= (state_next == IDLE);
      expose    <= (state_next == EXPOSE);
      nre_1     <= (state_next != READ1);
      nre_2     <= (state_next != READ2);
      adc       <= adc_next;
      busy      <= (state_next != IDLE);
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed bench for exposure_sequencer: frame timing, clamping, latching,
// ignored/held init, mid-frame reset, plus per-cycle output invariants.
module tb_exposure_sequencer;

  localparam int RD = 5;

  logic       clk;
  logic       reset;
  logic       init;
  logic [4:0] ex_time;
  logic       erase, expose, nre_1, nre_2, adc, busy, done;

  int checks   = 0;
  int failures = 0;
  logic armed  = 1'b0;

  exposure_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .init    (init),
    .ex_time (ex_time),
    .erase   (erase),
    .expose  (expose),
    .nre_1   (nre_1),
    .nre_2   (nre_2),
    .adc     (adc),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {erase, expose, nre_1, nre_2, adc, busy, done};
  endfunction

  // Output invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (armed) begin
      check("inv_nre_both_low", 32'(!nre_1 && !nre_2), 0);
      check("inv_expose_erase", 32'(expose && erase), 0);
      check("inv_adc_no_row", 32'(adc && nre_1 && nre_2), 0);
    end
  end

  // mode 0: single init pulse; 1: extra init pulses in EXPOSE/READ1/READ2;
  // 2: init held high; 3: ex_time changed to 20 during EXPOSE.
  task automatic run_frame(input string name, input logic [4:0] ex, input int n, input int mode);
    int mism, exp_w, done_n, busy_n, adc_n, k, last_j;
    logic r1, r2, last, adc_e;
    logic [6:0] expv;
    mism = 0; exp_w = 0; done_n = 0; busy_n = 0; adc_n = 0;
    last_j = n + 2 * RD + 1;
    init = 1'b1;
    ex_time = ex;
    @(posedge clk); #1;
    for (int j = 1; j <= last_j; j++) begin
      r1 = (j > n) && (j <= n + RD);
      r2 = (j > n + RD) && (j <= n + 2 * RD);
      k = r1 ? (j - n - 1) : (j - n - RD - 1);
      adc_e = (r1 || r2) && (k >= 1) && (k <= RD - 2);
      last = (j == last_j);
      expv = {last, (j <= n), !r1, !r2, adc_e, !last, last};
      if (outs() !== expv) mism++;
      if (expose) exp_w++;
      if (done) done_n++;
      if (busy) busy_n++;
      if (adc) adc_n++;
      case (mode)
        1: init = (j == 3) || (j == n + 2) || (j == n + 7);
        2: init = 1'b1;
        3: begin
          init = 1'b0;
          if (j == 3) ex_time = 5'd20;
        end
        default: init = 1'b0;
      endcase
      if (j < last_j) begin
        @(posedge clk); #1;
      end
    end
    check({name, "_expose_w"}, exp_w, n);
    check({name, "_busy_w"}, busy_n, n + 2 * RD);
    check({name, "_adc_n"}, adc_n, 2 * (RD - 2));
    check({name, "_done_n"}, done_n, 1);
    check({name, "_cycle_mism"}, mism, 0);
    $display("frame %s ex=%0d: expose=%0d busy=%0d adc=%0d done=%0d cycle_mismatches=%0d",
             name, ex, exp_w, busy_n, adc_n, done_n, mism);
  endtask

  task automatic idle_check(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (outs() !== 7'b1011000) bad++;
    end
    check(name, bad, 0);
    $display("idle %s: %0d cycles, non-idle cycles=%0d", name, cycles, bad);
  endtask

  initial begin
    int done_n, busy_n;
    reset = 1'b1;
    init = 1'b1;
    ex_time = 5'd15;
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    check("reset_outputs", outs(), 7'b1011000);
    $display("reset: outputs=%b", outs());
    reset = 1'b0;
    init = 1'b0;
    idle_check("idle_after_reset", 3);

    run_frame("basic15", 5'd15, 15, 0);
    idle_check("idle_a", 2);
    run_frame("clamp0", 5'd0, 2, 0);
    run_frame("clamp31", 5'd31, 30, 0);
    run_frame("pass2", 5'd2, 2, 0);
    run_frame("pass30", 5'd30, 30, 0);
    idle_check("idle_b", 2);

    run_frame("latch15", 5'd15, 15, 3);
    run_frame("next20", 5'd20, 20, 0);
    idle_check("idle_c", 2);

    run_frame("ignore_init", 5'd10, 10, 1);
    idle_check("idle_after_ignore", 4);

    run_frame("held_a", 5'd7, 7, 2);
    run_frame("held_b", 5'd7, 7, 2);
    run_frame("held_c", 5'd7, 7, 0);
    idle_check("idle_d", 2);

    // Abort in READ1 phase cycle 2 (observation n+2 of an 8-cycle exposure).
    init = 1'b1;
    ex_time = 5'd8;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_in_read1", 32'(nre_1), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs", outs(), 7'b1011000);
    $display("abort: outputs after reset edge=%b", outs());
    reset = 1'b0;
    done_n = 0;
    busy_n = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) done_n++;
      if (busy) busy_n++;
    end
    check("abort_no_done", done_n, 0);
    check("abort_no_busy", busy_n, 0);
    $display("abort: done pulses=%0d busy cycles=%0d", done_n, busy_n);
    run_frame("post_reset5", 5'd5, 5, 0);
    idle_check("idle_end", 2);

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
